// File: rtl/des_iterative_core.sv
// Iterative single-DES encrypt/decrypt core. It runs ROUNDS_PER_CYCLE Feistel rounds per clock.
// Round keys are derived on the fly: C/D rotate left for encrypt and right for decrypt.
module des_iterative_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_decrypt,
    input  logic [63:0] i_key,
    input  logic [63:0] i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [63:0] o_data,
    output logic        o_busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
          ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_rounds
        $error("des_iterative_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [4:0] RPC = 5'(ROUNDS_PER_CYCLE);

    // Bit n of these masks is set when 0-based round n rotates by one position instead of two.
    localparam logic [15:0] ENC_ONE = 16'b1000_0001_0000_0011;
    localparam logic [15:0] DEC_ONE = 16'b1000_0001_0000_0010;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Each box is stored row-major: index = {b1, b6, b2..b5}.
    localparam int SBOX_T [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    // Tables use DES numbering (bit 1 = MSB), so DES bit n sits at vector index WIDTH-n.
    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        x = '0;
        s = '0;
        y = '0;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int i = 0; i < 8; i++) begin
            b = x[47-6*i -: 6];
            s[31-4*i -: 4] = 4'(SBOX_T[i][{b[5], b[0], b[4:1]}]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    // Decrypt walks the schedule backwards, and its first round uses the unrotated halves.
    function automatic logic [27:0] rot_key(input logic [27:0] x, input logic [4:0] idx,
                                            input logic dec);
        logic [27:0] y;
        if (!dec)
            y = ENC_ONE[idx[3:0]] ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
        else if (idx == 5'd0)
            y = x;
        else
            y = DEC_ONE[idx[3:0]] ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
        return y;
    endfunction

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e      state_q;
    logic        ready_q, valid_q, busy_q, dec_q;
    logic [4:0]  rnd_q;
    logic [31:0] l_q, r_q, l_d, r_d;
    logic [27:0] c_q, d_q, c_d, d_d;
    logic [63:0] data_q;

    // The parity bits of the key never reach PC-1.
    logic unused_key_parity;
    assign unused_key_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                                 i_key[24], i_key[16], i_key[8], i_key[0]};

    for (genvar s = 0; s < ROUNDS_PER_CYCLE; s++) begin : g_round
        logic [27:0] c_in, d_in, c_out, d_out;
        logic [31:0] l_in, r_in, l_out, r_out;
        if (s == 0) begin : g_first
            assign c_in = c_q;
            assign d_in = d_q;
            assign l_in = l_q;
            assign r_in = r_q;
        end else begin : g_chain
            assign c_in = g_round[s-1].c_out;
            assign d_in = g_round[s-1].d_out;
            assign l_in = g_round[s-1].l_out;
            assign r_in = g_round[s-1].r_out;
        end
        assign c_out = rot_key(c_in, rnd_q + 5'(s), dec_q);
        assign d_out = rot_key(d_in, rnd_q + 5'(s), dec_q);
        assign l_out = r_in;
        assign r_out = l_in ^ f_func(r_in, perm_pc2({c_out, d_out}));
    end

    assign c_d = g_round[ROUNDS_PER_CYCLE-1].c_out;
    assign d_d = g_round[ROUNDS_PER_CYCLE-1].d_out;
    assign l_d = g_round[ROUNDS_PER_CYCLE-1].l_out;
    assign r_d = g_round[ROUNDS_PER_CYCLE-1].r_out;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            dec_q   <= 1'b0;
            rnd_q   <= '0;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        {l_q, r_q} <= perm_ip(i_data);
                        {c_q, d_q} <= perm_pc1(i_key);
                        dec_q      <= i_decrypt;
                        rnd_q      <= '0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_q   <= l_d;
                    r_q   <= r_d;
                    c_q   <= c_d;
                    d_q   <= d_d;
                    rnd_q <= rnd_q + RPC;
                    // The swapped pair {r_d, l_d} is exactly R16||L16, so the last swap is undone here.
                    if (rnd_q + RPC == 5'd16) begin
                        data_q  <= perm_fp({r_d, l_d});
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_des_iterative_core.sv
// Bench for des_iterative_core: five instances (1/2/4/8/16 rounds per clock) share one stimulus stream.
// Results are compared with a DES reference that precomputes all sixteen subkeys.
module tb_des_iterative_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_decrypt = 1'b0;
    logic        i_ready = 1'b1;
    logic [63:0] i_key = '0;
    logic [63:0] i_data = '0;
    logic [4:0]  o_ready_v, o_valid_v, o_busy_v;
    logic [63:0] o_data_a [5];

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
    localparam logic [63:0] P2 = 64'h8787878787878787;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        des_iterative_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .i_clk    (clk),
            .i_rst_n  (rst_n),
            .i_valid  (i_valid),
            .o_ready  (o_ready_v[g]),
            .i_decrypt(i_decrypt),
            .i_key    (i_key),
            .i_data   (i_data),
            .o_valid  (o_valid_v[g]),
            .i_ready  (i_ready),
            .o_data   (o_data_a[g]),
            .o_busy   (o_busy_v[g])
        );
    end

    localparam int IP [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};
    localparam int FP [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};
    localparam int EX [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
    localparam int PP [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10, 23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2, 41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Textbook DES: build K1..K16 up front, decrypt just consumes them in reverse.
    function automatic logic [63:0] des_ref(input logic [63:0] key, input logic [63:0] blk,
                                            input bit dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [47:0] x;
        logic [63:0] m, res;
        logic [31:0] l, r, s, t;
        logic [5:0]  b;
        for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < SHIFTS[k]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[k][47-i] = cd[56-PC2[i]];
        end
        for (int i = 0; i < 64; i++) m[63-i] = blk[64-IP[i]];
        l = m[63:32];
        r = m[31:0];
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 48; i++) x[47-i] = r[32-EX[i]];
            x = x ^ ks[dec ? 15 - k : k];
            for (int i = 0; i < 8; i++) begin
                b = x[47-6*i -: 6];
                s[31-4*i -: 4] = 4'(SB[i][32*b[5] + 16*b[0] + b[4:1]]);
            end
            for (int i = 0; i < 32; i++) t[31-i] = s[32-PP[i]];
            t = l ^ t;
            l = r;
            r = t;
        end
        m = {r, l};
        for (int i = 0; i < 64; i++) res[63-i] = m[64-FP[i]];
        return res;
    endfunction

    // One transfer through all instances; each must deliver exp after 16/R cycles with busy for 16/R.
    task automatic run_op(input logic [63:0] key, input logic [63:0] data, input bit dec,
                          input logic [63:0] exp, input bit scramble, input string name);
        int first_v [5];
        int busy_n [5];
        int guard;
        guard = 0;
        while (o_ready_v !== 5'b11111 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (o_ready_v !== 5'b11111) begin
            errors++;
            $display("FAIL %s ready_wait: got o_ready=%b expected 11111", name, o_ready_v);
        end
        i_key = key;
        i_data = data;
        i_decrypt = dec;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int g = 0; g < 5; g++) begin
            first_v[g] = -1;
            busy_n[g] = 0;
        end
        for (int cyc = 0; cyc <= 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (scramble) begin
                i_key = {$urandom, $urandom};
                i_data = {$urandom, $urandom};
                i_decrypt = 1'($urandom_range(0, 1));
            end
            for (int g = 0; g < 5; g++) begin
                if (o_busy_v[g] === 1'b1) busy_n[g]++;
                if (o_valid_v[g] === 1'b1 && first_v[g] < 0) begin
                    first_v[g] = cyc;
                    checks++;
                    if (o_data_a[g] !== exp) begin
                        errors++;
                        $display("FAIL %s data dut%0d: got %h expected %h", name, g, o_data_a[g], exp);
                    end
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (first_v[g] != (16 >> g)) begin
                errors++;
                $display("FAIL %s latency dut%0d: got %0d expected %0d", name, g, first_v[g], 16 >> g);
            end
            checks++;
            if (busy_n[g] != (16 >> g)) begin
                errors++;
                $display("FAIL %s busy_cycles dut%0d: got %0d expected %0d", name, g, busy_n[g], 16 >> g);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({o_ready_v[g], o_valid_v[g], o_busy_v[g]} !== 3'b100 || o_data_a[g] !== 64'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got rdy/vld/bsy=%b%b%b data=%h expected 100 data=0",
                         g, o_ready_v[g], o_valid_v[g], o_busy_v[g], o_data_a[g]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({o_ready_v[g], o_valid_v[g], o_busy_v[g]} !== 3'b100) begin
                errors++;
                $display("FAIL post_reset_idle dut%0d: got rdy/vld/bsy=%b%b%b expected 100",
                         g, o_ready_v[g], o_valid_v[g], o_busy_v[g]);
            end
        end
    endtask

    task automatic test_known_vectors();
        logic [63:0] m;
        m = des_ref(K1, P1, 1'b0);
        checks++;
        if (m !== C1) begin
            errors++;
            $display("FAIL model_kat: got %h expected %h", m, C1);
        end
        run_op(K1, P1, 1'b0, C1, 1'b0, "kat_enc");
        run_op(K1, C1, 1'b1, P1, 1'b0, "kat_dec");
        run_op(K2, P2, 1'b0, 64'h0, 1'b0, "kat_enc2");
        run_op(K2, 64'h0, 1'b1, P2, 1'b0, "kat_dec2");
    endtask

    task automatic test_random_roundtrip();
        logic [63:0] key, pt, ct;
        for (int n = 0; n < 1000; n++) begin
            key = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            ct = des_ref(key, pt, 1'b0);
            run_op(key, pt, 1'b0, ct, 1'b0, "rand_enc");
            run_op(key, ct, 1'b1, pt, 1'b0, "rand_dec");
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] key, pt, exp;
        int guard;
        key = {$urandom, $urandom};
        pt = {$urandom, $urandom};
        exp = des_ref(key, pt, 1'b0);
        i_ready = 1'b0;
        i_key = key;
        i_data = pt;
        i_decrypt = 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        guard = 0;
        while (o_valid_v[0] !== 1'b1 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (o_valid_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_valid_timeout: got o_valid=%b expected 1", o_valid_v[0]);
        end
        for (int c = 0; c < 5; c++) begin
            i_valid = 1'b1;
            i_key = {$urandom, $urandom};
            i_data = {$urandom, $urandom};
            @(negedge clk);
            for (int g = 0; g < 5; g++) begin
                checks++;
                if ({o_ready_v[g], o_valid_v[g], o_busy_v[g]} !== 3'b010 || o_data_a[g] !== exp) begin
                    errors++;
                    $display("FAIL bp_hold dut%0d: got rdy/vld/bsy=%b%b%b data=%h expected 010 data=%h",
                             g, o_ready_v[g], o_valid_v[g], o_busy_v[g], o_data_a[g], exp);
                end
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({o_ready_v[g], o_valid_v[g]} !== 2'b10 || o_data_a[g] !== exp) begin
                errors++;
                $display("FAIL bp_release dut%0d: got rdy/vld=%b%b data=%h expected 10 data=%h",
                         g, o_ready_v[g], o_valid_v[g], o_data_a[g], exp);
            end
        end
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({o_ready_v[g], o_busy_v[g]} !== 2'b10) begin
                errors++;
                $display("FAIL bp_no_accept dut%0d: got rdy/bsy=%b%b expected 10",
                         g, o_ready_v[g], o_busy_v[g]);
            end
        end
    endtask

    task automatic test_midrun_corruption();
        logic [63:0] key, pt;
        bit dec;
        run_op(K1, P1, 1'b0, C1, 1'b1, "midrun_kat");
        for (int n = 0; n < 6; n++) begin
            key = {$urandom, $urandom};
            pt = {$urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            run_op(key, pt, dec, des_ref(key, pt, dec), 1'b1, "midrun_rand");
        end
        i_decrypt = 1'b0;
    endtask

    task automatic test_async_reset();
        i_key = K1;
        i_data = P1;
        i_decrypt = 1'b0;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (o_busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL areset_midrun_busy: got o_busy=%b expected 1", o_busy_v[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 5; g++) begin
            checks++;
            if ({o_ready_v[g], o_valid_v[g], o_busy_v[g]} !== 3'b100 || o_data_a[g] !== 64'h0) begin
                errors++;
                $display("FAIL areset_outputs dut%0d: got rdy/vld/bsy=%b%b%b data=%h expected 100 data=0",
                         g, o_ready_v[g], o_valid_v[g], o_busy_v[g], o_data_a[g]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(K1, P1, 1'b0, C1, 1'b0, "areset_fresh_enc");
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_midrun_corruption();
        test_async_reset();
        test_random_roundtrip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/des_iterative_core.md
Name: des_iterative_core

Overview:
Iterative single-DES encrypt/decrypt engine built around the team's combinational DES f-function (expansion, key XOR, S-boxes, P-permutation). It runs the 16 Feistel rounds over multiple clock cycles and generates the round keys on the fly from a 64-bit key. ROUNDS_PER_CYCLE unrolls the f-function to trade area for latency. It has valid/ready handshakes on both sides, for use under a future 3DES/mode-of-operation wrapper.

Parameters:
ROUNDS_PER_CYCLE, 1, Feistel rounds per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input block/key/mode valid
o_ready  output  1  core can accept an input this cycle
i_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept
i_key  input  64  DES key incl. parity bits (bit 63 = DES bit 1); parity ignored; sampled on accept
i_data  input  64  plaintext or ciphertext (bit 63 = DES bit 1); sampled on accept
o_valid  output  1  result valid
i_ready  input  1  downstream accepts result
o_data  output  64  result block
o_busy  output  1  high while rounds are in progress

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_valid=0, o_busy=0, o_data=0, round counter=0, internal L/R/C/D registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=1. When i_valid=1 the input is accepted and the core does the following on that edge:
  - Load L/R = IP(i_data).
  - Load C/D = PC-1(i_key).
  - Latch mode, clear round counter, go to RUN.
- RUN: o_ready=0, o_busy=1. Each cycle applies ROUNDS_PER_CYCLE chained Feistel rounds: L'=R, R'=L^f(R,K). The round counter advances by ROUNDS_PER_CYCLE.
- The last round of 16 omits the L/R swap. The core then registers o_data=FP(R16||L16) and goes to DONE.
- Latency: the accept edge plus 16/ROUNDS_PER_CYCLE RUN cycles. o_valid rises 16/ROUNDS_PER_CYCLE cycles after the accept edge (16 for R=1, 1 for R=16).
- Key schedule, encrypt: before round k, C and D each rotate left by SHIFT[k]. SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. K_k = PC-2(C||D).
- Key schedule, decrypt:
  - Round 1 uses PC-2 of the unrotated C0/D0.
  - Before round k≥2, C and D each rotate right by SHIFT[18-k].
  - This yields K16..K1 in order without storing keys.
- Unrolled rounds in one cycle each compute their own rotated C/D combinationally from the previous stage's value. Only the value after the last stage is registered.
- DONE: o_valid=1, o_busy=0, o_ready=0.
  - o_data holds stable while i_ready=0.
  - On o_valid&i_ready: o_valid drops next cycle and the FSM returns to IDLE.
  - No input is accepted in the same cycle as the output transfer. Peak throughput is one block per 16/R+2 cycles.
- i_valid while o_ready=0 is ignored. Upstream must hold i_valid and all inputs until o_ready.
- Input signals are not re-sampled during RUN. Changing i_key/i_data/i_decrypt mid-run has no effect.
- Async reset in RUN or DONE aborts immediately to the reset values. No partial result is ever presented.
- o_data changes only on the final-round edge and on reset.

Test Plan:
- Encrypt, R=1: key 133457799BBCDFF1, data 0123456789ABCDEF -> o_data 85E813540F0AB405. o_valid exactly 16 cycles after accept; o_busy high for 16 cycles.
- Decrypt, R=1: same key, data 85E813540F0AB405 -> 0123456789ABCDEF. Then encrypt with key 0E329232EA6D0D73, data 8787878787878787 -> 0000000000000000.
- Sweep R=2,4,8,16 with both vectors: identical results; latency 8/4/2/1 cycles. Random key/data, decrypt(encrypt(x))==x for 1000 blocks, against a reference model.
- Backpressure: hold i_ready=0 for 5 cycles in DONE. o_data and o_valid stay stable, o_ready stays 0, and a new i_valid is ignored. Release i_ready -> IDLE next cycle.
- Mid-run corruption: toggle i_key, i_data and i_decrypt every cycle during RUN -> result still equals the vector for the values latched at accept.
- Async reset: assert i_rst_n=0 at round 7 (between clock edges) -> outputs immediately reset (o_ready=1, o_valid=0, o_data=0). A fresh encrypt after release gives the correct result.
